// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse keyer: FSM states, the packed
// code word format, symbol/gap unit counts and the code-building helper.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    DECODE = 3'd2,
    MARK   = 3'd3,
    SPACE  = 3'd4,
    GAP    = 3'd5
  } state_t;

  // len = symbol count (1..5); pattern consumed LSB-first, 1 = dash
  typedef struct packed {
    logic [2:0] len;
    logic [4:0] pattern;
  } code_t;

  localparam logic [2:0] DOT_UNITS        = 3'd1;
  localparam logic [2:0] DASH_UNITS       = 3'd3;
  localparam logic [2:0] SYM_GAP_UNITS    = 3'd1;
  localparam logic [2:0] LETTER_GAP_UNITS = 3'd3;
  localparam logic [2:0] WORD_EXTRA_UNITS = 3'd4;
  localparam logic [7:0] ASCII_SPACE      = 8'h20;

  // Build a code from the symbols written in reading order (first symbol is
  // the most significant of the len low bits) so the table reads like Morse.
  function automatic code_t mk(input logic [2:0] len, input logic [4:0] seq);
    logic [4:0] rev;
    code_t      c;
    rev       = {seq[0], seq[1], seq[2], seq[3], seq[4]};
    c.len     = len;
    c.pattern = rev >> (3'd5 - len);
    return c;
  endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational ASCII -> Morse lookup. Folds a-z onto A-Z; flags space
// separately; anything else comes back invalid.
module morse_rom
  import morse_pkg::*;
(
  input  logic [6:0] ascii_i,
  output logic       valid_o,
  output logic       is_space_o,
  output code_t      code_o
);

  logic [6:0] up;

  // Case fold lowercase letters onto uppercase
  always_comb begin
    up = ascii_i;
    if (ascii_i >= 7'h61 && ascii_i <= 7'h7A) up = ascii_i - 7'h20;
  end

  // Table lookup; unsupported characters leave valid low
  always_comb begin
    valid_o    = 1'b1;
    is_space_o = 1'b0;
    code_o     = '0;
    unique case (up)
      7'h41: code_o = mk(3'd2, 5'b01);     // A .-
      7'h42: code_o = mk(3'd4, 5'b1000);   // B -...
      7'h43: code_o = mk(3'd4, 5'b1010);   // C -.-.
      7'h44: code_o = mk(3'd3, 5'b100);    // D -..
      7'h45: code_o = mk(3'd1, 5'b0);      // E .
      7'h46: code_o = mk(3'd4, 5'b0010);   // F ..-.
      7'h47: code_o = mk(3'd3, 5'b110);    // G --.
      7'h48: code_o = mk(3'd4, 5'b0000);   // H ....
      7'h49: code_o = mk(3'd2, 5'b00);     // I ..
      7'h4A: code_o = mk(3'd4, 5'b0111);   // J .---
      7'h4B: code_o = mk(3'd3, 5'b101);    // K -.-
      7'h4C: code_o = mk(3'd4, 5'b0100);   // L .-..
      7'h4D: code_o = mk(3'd2, 5'b11);     // M --
      7'h4E: code_o = mk(3'd2, 5'b10);     // N -.
      7'h4F: code_o = mk(3'd3, 5'b111);    // O ---
      7'h50: code_o = mk(3'd4, 5'b0110);   // P .--.
      7'h51: code_o = mk(3'd4, 5'b1101);   // Q --.-
      7'h52: code_o = mk(3'd3, 5'b010);    // R .-.
      7'h53: code_o = mk(3'd3, 5'b000);    // S ...
      7'h54: code_o = mk(3'd1, 5'b1);      // T -
      7'h55: code_o = mk(3'd3, 5'b001);    // U ..-
      7'h56: code_o = mk(3'd4, 5'b0001);   // V ...-
      7'h57: code_o = mk(3'd3, 5'b011);    // W .--
      7'h58: code_o = mk(3'd4, 5'b1001);   // X -..-
      7'h59: code_o = mk(3'd4, 5'b1011);   // Y -.--
      7'h5A: code_o = mk(3'd4, 5'b1100);   // Z --..
      7'h30: code_o = mk(3'd5, 5'b11111);  // 0
      7'h31: code_o = mk(3'd5, 5'b01111);  // 1
      7'h32: code_o = mk(3'd5, 5'b00111);  // 2
      7'h33: code_o = mk(3'd5, 5'b00011);  // 3
      7'h34: code_o = mk(3'd5, 5'b00001);  // 4
      7'h35: code_o = mk(3'd5, 5'b00000);  // 5
      7'h36: code_o = mk(3'd5, 5'b10000);  // 6
      7'h37: code_o = mk(3'd5, 5'b11000);  // 7
      7'h38: code_o = mk(3'd5, 5'b11100);  // 8
      7'h39: code_o = mk(3'd5, 5'b11110);  // 9
      default: begin
        if (up == ASCII_SPACE[6:0]) is_space_o = 1'b1;
        else                        valid_o    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/morse_tx.sv
// Morse keyer on the read side of the character FIFO: pops one byte,
// looks up its code and keys dots/dashes with unit-timed gaps.
// Optional build macro MORSE_TX_TONE_EN adds a gated square-wave tone_o.
module morse_tx
  import morse_pkg::*;
#(
  parameter int WORD_BITS   = 8,
  parameter int UNIT_CYCLES = 6000000
`ifdef MORSE_TX_TONE_EN
  , parameter int TONE_HALF_CYCLES = 25000
`endif
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 fifo_empty_i,
  input  logic [WORD_BITS-1:0] fifo_rdata_i,
  output logic                 fifo_read_o,
  output logic                 key_o,
  output logic                 busy_o
`ifdef MORSE_TX_TONE_EN
  , output logic               tone_o
`endif
);

  localparam int UW = $clog2(UNIT_CYCLES);

  state_t        state_q, state_d;
  logic [6:0]    char_q;
  logic [4:0]    pat_q;
  logic [2:0]    len_q;
  logic [2:0]    units_q;
  logic [UW-1:0] unit_cnt_q;
  logic          timed, tick, last_unit;
  logic          rom_valid, rom_space;
  code_t         rom_code;
  logic          key_q, read_q, key_d, read_d;

  // Upper word bits carry no ASCII meaning
  if (WORD_BITS > 7) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^fifo_rdata_i[WORD_BITS-1:7];
  end

  morse_rom u_rom (
    .ascii_i    (char_q),
    .valid_o    (rom_valid),
    .is_space_o (rom_space),
    .code_o     (rom_code)
  );

  assign timed     = (state_q == MARK) || (state_q == SPACE) || (state_q == GAP);
  assign tick      = timed && (unit_cnt_q == UW'(UNIT_CYCLES - 1));
  assign last_unit = tick && (units_q == 3'd1);

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty_i) state_d = POP;
      POP:     state_d = DECODE;
      DECODE:  state_d = !rom_valid ? IDLE : (rom_space ? GAP : MARK);
      MARK:    if (last_unit) state_d = (len_q > 3'd1) ? SPACE : GAP;
      SPACE:   if (last_unit) state_d = MARK;
      GAP:     if (last_unit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs follow the next state so the flops line up with the state register
  always_comb begin
    key_d  = (state_d == MARK);
    read_d = (state_d == POP);
  end

  // Output flops
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      key_q  <= 1'b0;
      read_q <= 1'b0;
    end else begin
      key_q  <= key_d;
      read_q <= read_d;
    end
  end

  // Unit timer: restarts at 0 on every entry into a timed state
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)               unit_cnt_q <= '0;
    else if (!timed || tick)   unit_cnt_q <= '0;
    else                       unit_cnt_q <= unit_cnt_q + UW'(1);
  end

  // Character latch, symbol shifter and units-remaining counter
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      char_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      units_q <= '0;
    end else begin
      if (state_q == IDLE && !fifo_empty_i) char_q <= fifo_rdata_i[6:0];
      if (state_q == DECODE) begin
        pat_q   <= rom_code.pattern;
        len_q   <= rom_code.len;
        units_q <= rom_space ? WORD_EXTRA_UNITS
                             : (rom_code.pattern[0] ? DASH_UNITS : DOT_UNITS);
      end else if (state_q == MARK && last_unit) begin
        pat_q   <= pat_q >> 1;
        len_q   <= len_q - 3'd1;
        units_q <= (len_q > 3'd1) ? SYM_GAP_UNITS : LETTER_GAP_UNITS;
      end else if (state_q == SPACE && last_unit) begin
        units_q <= pat_q[0] ? DASH_UNITS : DOT_UNITS;
      end else if (tick) begin
        units_q <= units_q - 3'd1;
      end
    end
  end

  assign key_o       = key_q;
  assign fifo_read_o = read_q;
  assign busy_o      = (state_q != IDLE);

`ifdef MORSE_TX_TONE_EN
  localparam int TW = (TONE_HALF_CYCLES > 1) ? $clog2(TONE_HALF_CYCLES) : 1;

  logic [TW-1:0] tone_cnt_q;
  logic          tone_q;

  // Tone generator held at phase 0 whenever the key is up
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i || !key_q) begin
      tone_cnt_q <= '0;
      tone_q     <= 1'b0;
    end else if (tone_cnt_q == TW'(TONE_HALF_CYCLES - 1)) begin
      tone_cnt_q <= '0;
      tone_q     <= ~tone_q;
    end else begin
      tone_cnt_q <= tone_cnt_q + TW'(1);
    end
  end

  assign tone_o = tone_q & key_q;
`endif

endmodule

// File: tb/tb_morse_tx.sv
// Bench for morse_tx with UNIT_CYCLES=4: a FIFO queue model feeds bytes, and
// a timeline model built from the Morse alphabet gives per-cycle expectations.
module tb_morse_tx;

  localparam int U = 4;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       fifo_empty_i = 1'b1;
  logic [7:0] fifo_rdata_i = 8'h00;
  logic       fifo_read_o, key_o, busy_o;
`ifdef MORSE_TX_TONE_EN
  logic       tone_o;
  logic       prev_tone = 1'b0;
`endif

  int  total = 0;
  int  bad = 0;
  int  npops = 0;
  logic prev_key = 1'b0;
  byte unsigned fq[$];
  byte unsigned stim[$];

  string let_tab[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                         "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                         "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                         "-.--", "--.."};
  string dig_tab[10] = '{"-----", ".----", "..---", "...--", "....-",
                         ".....", "-....", "--...", "---..", "----."};

  morse_tx #(
    .WORD_BITS   (8),
    .UNIT_CYCLES (U)
`ifdef MORSE_TX_TONE_EN
    , .TONE_HALF_CYCLES (1)
`endif
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_read_o  (fifo_read_o),
    .key_o        (key_o),
    .busy_o       (busy_o)
`ifdef MORSE_TX_TONE_EN
    , .tone_o     (tone_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void fifo_set();
    fifo_empty_i = (fq.size() == 0);
    fifo_rdata_i = (fq.size() == 0) ? 8'h00 : fq[0];
  endfunction

  // Per-cycle bookkeeping after sampling: handshake check, tone, FIFO pop
  task automatic mon();
    if (fifo_read_o) begin
      npops++;
      chk("pop_nonempty", 32'(fifo_empty_i), 32'd0);
      if (fq.size() > 0) void'(fq.pop_front());
    end
`ifdef MORSE_TX_TONE_EN
    if (!key_o)        chk("tone_off", 32'(tone_o), 32'd0);
    else if (!prev_key) chk("tone_ph0", 32'(tone_o), 32'd0);
    else               chk("tone_tgl", 32'(tone_o), 32'(!prev_tone));
    prev_tone = tone_o;
`endif
    prev_key = key_o;
    fifo_set();
  endtask

  function automatic string code_of(input byte unsigned c, output bit sp);
    byte unsigned a;
    a  = c & 8'h7f;
    sp = (a == 8'h20);
    if (a >= 8'h61 && a <= 8'h7a) a = a - 8'h20;
    if (a >= 8'h41 && a <= 8'h5a) return let_tab[int'(a) - 65];
    if (a >= 8'h30 && a <= 8'h39) return dig_tab[int'(a) - 48];
    return "";
  endfunction

  // Reset with stim loaded, release, then compare {read,key,busy} per cycle
  task automatic run_seq();
    logic [2:0] expq[$];
    string s;
    bit sp;
    reset_i = 1'b1;
    fq = stim;
    fifo_set();
    repeat (2) begin
      @(negedge clk_i);
      chk("rst_outs", 32'({fifo_read_o, key_o, busy_o}), 32'd0);
      mon();
    end
    foreach (stim[c]) begin
      s = code_of(stim[c], sp);
      expq.push_back(3'b000);  // idle sample
      expq.push_back(3'b101);  // pop
      expq.push_back(3'b001);  // decode
      if (sp) repeat (4 * U) expq.push_back(3'b001);
      else if (s.len() > 0) begin
        for (int i = 0; i < s.len(); i++) begin
          repeat ((s[i] == 8'h2d ? 3 : 1) * U) expq.push_back(3'b011);
          if (i < s.len() - 1) repeat (U) expq.push_back(3'b001);
        end
        repeat (3 * U) expq.push_back(3'b001);
      end
    end
    repeat (6) expq.push_back(3'b000);
    npops = 0;
    reset_i = 1'b0;
    for (int i = 1; i < expq.size(); i++) begin
      @(negedge clk_i);
      chk($sformatf("trace%0d", i), 32'({fifo_read_o, key_o, busy_o}), 32'(expq[i]));
      mon();
    end
    chk("pop_count", 32'(npops), 32'(stim.size()));
  endtask

  initial begin
    int n, k, c;

    // directed sequences
    stim = '{8'h45};               run_seq();  // E
    stim = '{8'h41};               run_seq();  // A
    stim = '{8'h45, 8'h20, 8'h45}; run_seq();  // E E
    stim = '{8'h65};               run_seq();  // e
    stim = '{8'h23, 8'h54};        run_seq();  // # T
    stim = '{8'h30, 8'hC5};        run_seq();  // 0, E with bit 7 set

    // empty FIFO held for 100 cycles
    reset_i = 1'b1; fq.delete(); fifo_set();
    @(negedge clk_i); mon();
    reset_i = 1'b0;
    repeat (100) begin
      @(negedge clk_i);
      chk("empty_read", 32'(fifo_read_o), 32'd0);
      chk("empty_busy", 32'(busy_o), 32'd0);
      mon();
    end

    // reset in the middle of a dash
    fq = '{8'h54}; fifo_set();
    for (int i = 0; i < 20 && !key_o; i++) begin
      @(negedge clk_i); mon();
    end
    chk("dash_start", 32'(key_o), 32'd1);
    repeat (5) begin @(negedge clk_i); mon(); end
    chk("dash_mid", 32'(key_o), 32'd1);
    reset_i = 1'b1;
    #1;
    chk("async_key", 32'(key_o), 32'd0);
    chk("async_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i); mon();
    reset_i = 1'b0;
    npops = 0;
    repeat (10) begin
      @(negedge clk_i);
      chk("post_rst_read", 32'(fifo_read_o), 32'd0);
      mon();
    end
    chk("post_rst_pops", 32'(npops), 32'd0);

    // randomized character strings
    repeat (8) begin
      stim.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        k = $urandom_range(0, 5);
        case (k)
          0: c = 'h41 + $urandom_range(0, 25);
          1: c = 'h61 + $urandom_range(0, 25);
          2: c = 'h30 + $urandom_range(0, 9);
          3: c = 'h20;
          4: c = $urandom_range('h21, 'h2f);
          default: c = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 'h1f) : 'h7f;
        endcase
        if ($urandom_range(0, 3) == 0) c = c | 'h80;
        stim.push_back(8'(c));
      end
      run_seq();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
